// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-facing signals of the hazard controller.
//   master : pipeline side (drives ID/EX/MEM status, receives controls)
//   slave  : hazard controller side
//   Status  : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread,
//             id_ex_rd, ex_branch_taken, mem_req, mem_ready
//   Control : pc_write, if_id_write, id_ex_write, ex_mem_write,
//             if_id_flush, id_ex_bubble, mem_wb_bubble
//   Status  : mem_timeout, stall_cnt, flush_cnt
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        mem_wb_bubble;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread,
           id_ex_rd, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_bubble, mem_wb_bubble,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread,
           id_ex_rd, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_bubble, mem_wb_bubble,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and stall controller for the 5-stage core: load-use bubbles,
//   taken-branch flushes, whole-pipeline freeze on slow data memory, a
//   memory-wait watchdog and stall/flush performance counters.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : hazard_ctrl_if.slave (pipeline status in, stage controls out)
// Parameter:
//   TIMEOUT_CYCLES : consecutive memory wait cycles tolerated (1..65535)
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT_CYCLES);

  state_t      state_reg;
  logic [15:0] wait_cnt_reg;
  logic        mem_timeout_reg;
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  logic [4:0]  src_rs [2];
  logic [1:0]  src_used;
  logic [1:0]  src_hit;
  logic        load_use;
  logic        mem_stall;
  logic        halted;
  logic [16:0] wait_inc;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_bubble, mem_wb_bubble;

  assign src_rs[0]   = bus.id_rs1;
  assign src_rs[1]   = bus.id_rs2;
  assign src_used[0] = bus.id_uses_rs1;
  assign src_used[1] = bus.id_uses_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_rs[gi] == bus.id_ex_rd);
    end
  endgenerate

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use  = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) && (|src_hit);
  assign mem_stall = bus.mem_req && !bus.mem_ready;
  // While rst is held the outputs behave as in RUN, whatever the register says.
  assign halted    = (state_reg == ERROR) && !rst;
  assign wait_inc  = {1'b0, wait_cnt_reg} + 17'd1;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (halted || mem_stall) begin
      // Freeze everything; a taken branch in EX stays put and is flushed
      // on the first cycle the freeze lifts.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // Beats load-use: the dependent ID instruction is squashed anyway.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 16'd0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= 32'd0;
      flush_cnt_reg   <= 32'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + {31'd0, ~pc_write};
      flush_cnt_reg <= flush_cnt_reg + {31'd0, if_id_flush};
      case (state_reg)
        RUN: begin
          if (mem_stall) begin
            // The RUN cycle that first sees the stall is wait cycle 1.
            if (17'd1 >= TIMEOUT_W) begin
              state_reg       <= ERROR;
              mem_timeout_reg <= 1'b1;
              wait_cnt_reg    <= 16'd0;
            end else begin
              state_reg    <= MEM_WAIT;
              wait_cnt_reg <= 16'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 16'd0;
          end else if (wait_inc >= TIMEOUT_W) begin
            state_reg       <= ERROR;
            mem_timeout_reg <= 1'b1;
            wait_cnt_reg    <= 16'd0;
          end else begin
            wait_cnt_reg <= wait_inc[15:0];
          end
        end
        ERROR: begin
          // Halted until rst.
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= 16'd0;
        end
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.id_ex_write   = id_ex_write;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_timeout   = mem_timeout_reg;
  assign bus.stall_cnt     = stall_cnt_reg;
  assign bus.flush_cnt     = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed scenarios followed by constrained-random cycles, each cycle
//   compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: halted flag, sticky timeout, run of consecutive stall
  // cycles, and the two event counters.
  bit          m_halted  = 1'b0;
  bit          m_timeout = 1'b0;
  int          m_consec  = 0;
  logic [31:0] m_stall   = 32'd0;
  logic [31:0] m_flush   = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc_w, ifid_w, idex_w, exmem_w, ifid_flush, idex_bubble, memwb_bubble}
  function automatic logic [6:0] exp_outs();
    bit lu, ms;
    lu = bus.id_ex_memread && (bus.id_ex_rd != 0) &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.id_ex_rd) ||
          (bus.id_uses_rs2 && bus.id_rs2 == bus.id_ex_rd));
    ms = bus.mem_req && !bus.mem_ready;
    if ((m_halted && !rst) || ms) return 7'b0000_001;
    if (bus.ex_branch_taken)      return 7'b1111_110;
    if (lu)                       return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  task automatic step();
    logic [6:0] e, o;
    @(negedge clk);
    e = exp_outs();
    o = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
         bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble};
    check("outs", 32'(o), 32'(e));
    @(posedge clk);
    if (rst) begin
      m_halted = 0; m_timeout = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall = m_stall + 32'(!e[6]);
      m_flush = m_flush + 32'(e[2]);
      if (!m_halted) begin
        if (bus.mem_req && !bus.mem_ready) begin
          m_consec++;
          if (m_consec >= T) begin
            m_halted  = 1;
            m_timeout = 1;
          end
        end else begin
          m_consec = 0;
        end
      end
    end
    #1;
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("flush_cnt", bus.flush_cnt, m_flush);
    check("mem_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
  endtask

  task automatic idle();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_ex_memread = 0; bus.id_ex_rd = 0; bus.ex_branch_taken = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    bit hold;
    idle();
    rst = 1; step(); step(); rst = 0;
    check("reset_stall", bus.stall_cnt, 32'd0);

    // Load-use on rs2
    bus.id_ex_memread = 1; bus.id_ex_rd = 5; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
    step();
    check("lu_stall_cnt", bus.stall_cnt, 32'd1);
    bus.id_ex_rd = 0; step();                          // x0: no hazard
    bus.id_ex_rd = 5; bus.id_uses_rs2 = 0; step();     // unused source
    check("lu_no_stall", bus.stall_cnt, 32'd1);
    idle(); step();

    // Branch overriding load-use
    do_reset();
    bus.id_ex_memread = 1; bus.id_ex_rd = 5; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
    bus.ex_branch_taken = 1; step();
    check("br_flush_cnt", bus.flush_cnt, 32'd1);
    check("br_stall_cnt", bus.stall_cnt, 32'd0);
    idle(); step();

    // 3-cycle memory wait
    do_reset();
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (3) step();
    bus.mem_ready = 1; step();
    check("memwait_stall", bus.stall_cnt, 32'd3);
    idle(); step();

    // Branch held through a 2-cycle wait
    do_reset();
    bus.ex_branch_taken = 1; bus.mem_req = 1; bus.mem_ready = 0;
    repeat (2) step();
    check("br_held_noflush", bus.flush_cnt, 32'd0);
    bus.mem_ready = 1; step();
    check("br_held_flush", bus.flush_cnt, 32'd1);
    idle(); step();

    // Watchdog timeout, then recovery by reset
    do_reset();
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (T + 3) step();
    check("timeout_flag", 32'(bus.mem_timeout), 32'd1);
    check("timeout_stall", bus.stall_cnt, 32'(T + 3));
    bus.mem_req = 0; step();                           // still halted
    check("halt_pc_write", 32'(bus.pc_write), 32'd0);
    rst = 1; step(); rst = 0;
    check("timeout_cleared", 32'(bus.mem_timeout), 32'd0);
    step();
    check("post_reset_stall", bus.stall_cnt, 32'd0);

    // Reset on wait cycle 2
    do_reset();
    bus.mem_req = 1; bus.mem_ready = 0; step();
    rst = 1; step(); rst = 0;
    check("midwait_stall", bus.stall_cnt, 32'd0);
    bus.mem_ready = 1; step();
    check("midwait_run", 32'(bus.pc_write), 32'd1);
    idle(); step();

    // Constrained random: the MEM instruction stays requested while waiting.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_uses_rs1     = 1'($urandom_range(0, 1));
      bus.id_uses_rs2     = 1'($urandom_range(0, 1));
      bus.id_ex_memread   = 1'($urandom_range(0, 1));
      bus.id_ex_rd        = 5'($urandom_range(0, 3));
      bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
      bus.mem_req         = hold || ($urandom_range(0, 2) == 0);
      bus.mem_ready       = ($urandom_range(0, 9) < 6);
      step();
      hold = bus.mem_req && !bus.mem_ready && !rst;
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC core. It covers the hazards that the forwarding unit cannot resolve:
- load-use dependencies, by inserting a bubble;
- taken branches resolved in EX, by flushing IF/ID and ID/EX;
- multi-cycle data-memory accesses, by freezing the whole pipeline until `mem_ready`.

It has a wait-state FSM with a timeout watchdog and 32-bit performance counters. It sits beside the forwarding unit and drives the write-enables and flush/bubble controls of the PC and the four pipeline registers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum consecutive memory wait cycles before the error is raised. Legal range 1..65535.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` input 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` input 1: the ID instruction actually reads that source.
- `id_ex_memread` input 1: the instruction in EX is a load.
- `id_ex_rd` input 5: destination register of the instruction in EX.
- `ex_branch_taken` input 1: branch or jump resolved taken in EX.
- `mem_req` input 1: the MEM-stage instruction is a load or store.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_write` output 1: PC update enable.
- `if_id_write` output 1: IF/ID register enable.
- `id_ex_write` output 1: ID/EX register enable.
- `ex_mem_write` output 1: EX/MEM register enable.
- `if_id_flush` output 1: load NOP into IF/ID.
- `id_ex_bubble` output 1: zero the control fields loaded into ID/EX.
- `mem_wb_bubble` output 1: zero the control fields loaded into MEM/WB.
- `mem_timeout` output 1: sticky error flag.
- `stall_cnt` output 32: total cycles with `pc_write` = 0.
- `flush_cnt` output 32: total branch flushes performed.

## Operation
Hazard terms (combinational):
- `load_use` = `id_ex_memread` && `id_ex_rd` != 0 && ((`id_uses_rs1` && `id_rs1` == `id_ex_rd`) || (`id_uses_rs2` && `id_rs2` == `id_ex_rd`)).
- `mem_stall` = `mem_req` && !`mem_ready`.

FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.

Outputs by state and priority (the first matching line applies):
- **ERROR:** all write-enables 0, `mem_wb_bubble` = 1, flushes 0. The core is halted until `rst`.
- **`mem_stall`** (in RUN or MEM_WAIT): `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` all 0; `mem_wb_bubble` = 1; `if_id_flush` = `id_ex_bubble` = 0.
  - A taken branch sitting in EX is held and is flushed on the first cycle the stall clears.
- **`ex_branch_taken`:** all enables 1; `if_id_flush` = 1; `id_ex_bubble` = 1.
  - This overrides `load_use`, because the ID instruction is discarded anyway.
- **`load_use`:** `pc_write` = `if_id_write` = 0; `id_ex_write` = 1; `id_ex_bubble` = 1; `ex_mem_write` = 1.
- **Otherwise:** all enables 1; flush and bubble 0.

FSM transitions:
- RUN → MEM_WAIT when `mem_stall`.
- MEM_WAIT → RUN when `mem_ready`.
- MEM_WAIT → ERROR when the wait counter reaches `TIMEOUT_CYCLES` with `mem_ready` still 0.

Wait counter (16-bit):
- Set to 1 on RUN → MEM_WAIT.
- Increments each MEM_WAIT cycle while `mem_ready` = 0.
- Cleared on leaving MEM_WAIT.
- Never wraps, since ERROR is entered first.

Counters:
- `stall_cnt` increments in every cycle with `pc_write` = 0, including ERROR.
- `flush_cnt` increments in every cycle with `if_id_flush` = 1.
- Both wrap modulo 2^32.

`mem_timeout` is set on entry to ERROR and cleared only by `rst`.

## Timing
- Hazard outputs are combinational from the current inputs and registered state, with zero-cycle latency. They are valid before the same rising edge that loads the pipeline registers.
- Load-use costs exactly 1 bubble cycle. On the next cycle the load is in MEM and `id_ex_memread` refers to the bubble, so the condition self-clears.
- Branch flush costs 2 squashed instructions and asserts for 1 cycle per taken branch.
- Memory wait of N cycles with `mem_req` = 1 and `mem_ready` = 0 gives N freeze cycles. The access completes on the cycle `mem_ready` = 1, which is not a stall cycle.
- With `mem_ready` = 1 on the first cycle there is no stall and no state change.
- The ERROR transition occurs at the clock edge ending the `TIMEOUT_CYCLES`-th consecutive wait cycle. `mem_timeout` is high from the next cycle.
- Reset (synchronous):
  - state = RUN; counters, wait counter and `mem_timeout` = 0.
  - During reset cycles the outputs follow the RUN equations on the current inputs.
  - Reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge.

## Test plan
- **Load-use:** `id_ex_memread` = 1, `id_ex_rd` = 5, `id_rs2` = 5, `id_uses_rs2` = 1 → one cycle with `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1; `stall_cnt` = 1. Repeat with `id_ex_rd` = 0 or `id_uses_rs2` = 0 → no stall.
- **Branch vs load-use:** `ex_branch_taken` = 1 together with a load-use match → `if_id_flush` = 1, `id_ex_bubble` = 1, `pc_write` = 1; `flush_cnt` = 1, `stall_cnt` unchanged.
- **Memory wait:** `mem_req` = 1, `mem_ready` low for 3 cycles then high → 3 freeze cycles with `mem_wb_bubble` = 1, state MEM_WAIT → RUN; `stall_cnt` = 3.
- **Branch held during memory wait:** `ex_branch_taken` = 1 during a 2-cycle memory wait → no flush during the wait; `if_id_flush` = 1 on the cycle `mem_ready` = 1; `flush_cnt` = 1.
- **Timeout:** `TIMEOUT_CYCLES` = 4, `mem_ready` held 0 → ERROR after 4 wait cycles, `mem_timeout` = 1, all enables 0 for as long as held. `rst` for 1 cycle → RUN, `mem_timeout` = 0, counters = 0.
- **Reset mid-wait:** `rst` asserted on wait cycle 2 → next cycle state is RUN, wait counter 0, `stall_cnt` = 0.
